// File: rtl/register_file.sv
// register_file: 32 x WIDTH LEGv8 register file with post-reset scrub and XZR at ZERO_REG
// Ports: Clk, Reset (sync, active-high); RA/RB async read addresses -> BusA/BusB;
// RW/RegWr/BusW synchronous write port; Ready high once every register is scrubbed.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through from BusW to the read ports.
module register_file #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       RA,
    input  logic [4:0]       RB,
    input  logic [4:0]       RW,
    input  logic             RegWr,
    input  logic [WIDTH-1:0] BusW,
    output logic [WIDTH-1:0] BusA,
    output logic [WIDTH-1:0] BusB,
    output logic             Ready
);
    localparam logic [4:0] ZR = 5'(ZERO_REG);
    typedef enum logic {CLEAR, READY} state_t;
    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [32];
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             byp_a, byp_b;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        wr_data = '0;
        if (Reset) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            cnt_d   = (cnt_q == 5'd30) ? 5'd0 : cnt_q + 5'd1;
            state_d = (cnt_q == 5'd30) ? READY : CLEAR;
        end else if (RegWr && RW != ZR) begin
            wr_en   = 1'b1;
            wr_addr = RW;
            wr_data = BusW;
        end
    end
    always_ff @(posedge Clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end
    assign Ready = (state_q == READY);
`ifdef REGFILE_BYPASS_EN
    assign byp_a = RegWr && RW != ZR && RA == RW;
    assign byp_b = RegWr && RW != ZR && RB == RW;
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif
    assign BusA = (!Ready || RA == ZR) ? '0 : byp_a ? BusW : mem_q[RA];
    assign BusB = (!Ready || RB == ZR) ? '0 : byp_b ? BusW : mem_q[RB];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file scrub, read/write, XZR and bypass
module tb_register_file;
    logic        Clk = 1'b0, Reset = 1'b1, RegWr = 1'b0;
    logic [4:0]  RA = 5'd0, RB = 5'd0, RW = 5'd0;
    logic [63:0] BusW = '0, BusA, BusB;
    logic        Ready;
    int          n_cmp = 0, n_bad = 0;
    typedef struct {string tag; int sel; logic [63:0] exp;} exp_t;
    exp_t        sb[$];
    logic [63:0] model [31];
    register_file dut (
        .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW), .RegWr(RegWr),
        .BusW(BusW), .BusA(BusA), .BusB(BusB), .Ready(Ready)
    );
    always #5 Clk = ~Clk;
    task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task push(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask
    task drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, (e.sel == 0) ? BusA : (e.sel == 1) ? BusB : {63'b0, Ready}, e.exp);
        end
    endtask
    task tick();
        @(posedge Clk);
        #1;
    endtask
    task scrub(input string tag);
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (i == 31) RegWr = 1'b0;
            push({tag, "_ready"}, 2, 64'(i == 31));
            if (i < 31) push({tag, "_busa"}, 0, 64'd0);
            drain();
        end
    endtask
    initial begin
        RA = 5'd5;
        RB = 5'd5;
        tick();
        tick();
        push("rst_ready", 2, 0);
        push("rst_busa", 0, 0);
        push("rst_busb", 1, 0);
        drain();
        Reset = 1'b0;
        scrub("scrub");
        RegWr = 1'b1; RW = 5'd3; BusW = 64'h0123_4567_89AB_CDEF;
        tick();
        RegWr = 1'b0; RA = 5'd3; RB = 5'd3;
        #1;
        push("wr_busa", 0, 64'h0123_4567_89AB_CDEF);
        push("wr_busb", 1, 64'h0123_4567_89AB_CDEF);
        drain();
        RegWr = 1'b1; RW = 5'd31; BusW = '1;
        tick();
        RegWr = 1'b0; RA = 5'd31; RB = 5'd31;
        #1;
        push("xzr_a", 0, 0);
        push("xzr_b", 1, 0);
        drain();
        for (int i = 0; i < 31; i++) begin
            model[i] = {$urandom, $urandom};
            RegWr = 1'b1; RW = 5'(i); BusW = model[i];
            tick();
        end
        RegWr = 1'b0;
        for (int i = 0; i < 31; i++) begin
            RA = 5'(i); RB = 5'(30 - i);
            #1;
            push("bulk_a", 0, model[i]);
            push("bulk_b", 1, model[30-i]);
            drain();
        end
        RegWr = 1'b1; RW = 5'd9; BusW = 64'h1111;
        tick();
        BusW = 64'h2222; RA = 5'd9; RB = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        push("same_cyc_a", 0, 64'h2222);
        push("same_cyc_b", 1, 64'h2222);
`else
        push("same_cyc_a", 0, 64'h1111);
        push("same_cyc_b", 1, 64'h1111);
`endif
        drain();
        tick();
        RegWr = 1'b0;
        #1;
        push("after_edge_a", 0, 64'h2222);
        drain();
        RegWr = 1'b1; RW = 5'd31; BusW = '1; RA = 5'd31;
        #1;
        push("xzr_byp", 0, 0);
        drain();
        RW = 5'd4; BusW = 64'h55;
        tick();
        RegWr = 1'b0; RA = 5'd4;
        #1;
        push("r4_set", 0, 64'h55);
        drain();
        Reset = 1'b1;
        tick();
        push("rdy_rst_ready", 2, 0);
        push("rdy_rst_busa", 0, 0);
        drain();
        Reset = 1'b0;
        scrub("scrub2");
        #1;
        push("r4_cleared", 0, 0);
        drain();
        Reset = 1'b1;
        tick();
        Reset = 1'b0; RegWr = 1'b1; RW = 5'd7; BusW = 64'hDEAD; RA = 5'd7;
        for (int i = 0; i < 15; i++) begin
            tick();
            push("partial_ready", 2, 0);
            drain();
        end
        Reset = 1'b1;
        tick();
        push("restart_ready", 2, 0);
        drain();
        Reset = 1'b0;
        scrub("restart");
        #1;
        push("blocked_wr", 0, 0);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
